imem_loader: RTL and testbench

Writes a program image into instruction memory before the core runs: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and drives the instruction memory's write port at consecutive word addresses. It sits beside the fetch stage. It writes the same memory that fetch reads, using the same byte-address width, and holds the core in reset while a load is in progress.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: loader FSM states and loader frame constants.
package pipeline_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK
    } loader_state_t;

    localparam int LOADER_LEN_BYTES = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; the word is presented
// combinationally on the strobe that fills lane 3.
module byte_packer
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx;
    logic [23:0] low_lanes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 2'd0;
            low_lanes <= 24'd0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            low_lanes <= 24'd0;
        end else if (strobe) begin
            case (byte_idx)
                2'd0:    low_lanes[7:0]   <= data;
                2'd1:    low_lanes[15:8]  <= data;
                2'd2:    low_lanes[23:16] <= data;
                default: low_lanes        <= low_lanes;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Lane 3 is never stored: the incoming byte completes the word directly.
    assign word       = {data, low_lanes};
    assign word_valid = strobe && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory
// as consecutive little-endian 32-bit words, holding the core via busy.
module imem_loader
    import pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [XLEN-1:0]       wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-2:0] words_loaded
);

    localparam int         DEPTH   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [15:0] DEPTH_N = 16'(DEPTH);

    loader_state_t         state, state_next;
    logic [15:0]           len;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH-2:0] word_idx;
    logic [ADDR_WIDTH-2:0] word_idx_inc;
    logic [7:0]            checksum;
    logic                  accept;
    logic                  pack_strobe;
    logic                  pack_clear;
    logic [31:0]           pack_word;
    logic                  pack_word_valid;

    assign s_ready      = (state != IDLE);
    assign accept       = s_valid && s_ready;
    assign len_full     = {s_data, len[7:0]};
    assign word_idx_inc = word_idx + 1'b1;
    assign words_loaded = word_idx;
    assign pack_strobe  = accept && (state == DATA);
    assign pack_clear   = (state == IDLE) && start;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .strobe     (pack_strobe),
        .data       (s_data),
        .word       (pack_word),
        .word_valid (pack_word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LEN0;
            LEN0: if (accept) state_next = LEN1;
            LEN1: begin
                if (accept) begin
                    if (len_full > DEPTH_N)      state_next = IDLE;
                    else if (len_full == 16'd0)  state_next = CHK;
                    else                         state_next = DATA;
                end
            end
            DATA: begin
                if (pack_word_valid && (16'(word_idx_inc) == len)) begin
                    state_next = CHK;
                end
            end
            CHK:  if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and flags; busy tracks the next state so it is registered
    // yet rises the cycle after start and falls the cycle after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= 16'd0;
            word_idx <= '0;
            checksum <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            we   <= 1'b0;
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_idx <= '0;
                        checksum <= 8'd0;
                        len      <= 16'd0;
                    end
                end
                LEN0: if (accept) len[7:0] <= s_data;
                LEN1: begin
                    if (accept) begin
                        len[15:8] <= s_data;
                        if (len_full > DEPTH_N) err <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum <= checksum ^ s_data;
                        if (pack_word_valid) begin
                            we       <= 1'b1;
                            waddr    <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                            wdata    <= pack_word;
                            word_idx <= word_idx_inc;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (s_data == checksum) done <= 1'b1;
                        else                    err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus queues expected writes, a monitor
// pops and compares them whenever we is seen.
module tb_imem_loader;

    localparam int AW = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-2:0] words_loaded;

    int  vectors     = 0;
    int  miscompares = 0;
    int  busy_cycles = 0;
    wr_t exp_q[$];

    imem_loader #(.XLEN(32), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n && busy) busy_cycles++;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", {24'd0, waddr}, {24'd0, e.addr});
                checkOutput("write_data", wdata, e.data);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gaps, input bit with_start);
        int waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        if (with_start) start = 1'b1;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL byte_timeout: s_ready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendFrame(input byte_q_t bytes, input bit gaps, input int start_at);
        for (int i = 0; i < bytes.size(); i++) begin
            applyStimulus(bytes[i], gaps, i == start_at);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        checkOutput({tag, "_we"}, {31'd0, we}, 32'd0);
        checkOutput({tag, "_waddr"}, {24'd0, waddr}, 32'd0);
        checkOutput({tag, "_wdata"}, wdata, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, "_words"}, {25'd0, words_loaded}, 32'd0);
    endtask

    task automatic checkFlags(input string tag, input logic d, input logic e,
                              input int words);
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, d});
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, e});
        checkOutput({tag, "_words"}, {25'd0, words_loaded}, 32'(words));
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic pushTwoWords();
        exp_q.push_back('{addr: 8'h00, data: 32'h0000_0013});
        exp_q.push_back('{addr: 8'h04, data: 32'h0010_0093});
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Checksum covers every data byte: 0x13 ^ 0x93 ^ 0x10 = 0x90.
        byte_q_t good_frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        byte_q_t bad_frame  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        byte_q_t part_frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};

        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] two-word load");
        pushTwoWords();
        pulseStart();
        checkOutput("t1_busy_rise", {31'd0, busy}, 32'd1);
        sendFrame(good_frame, 1'b0, -1);
        checkFlags("t1", 1'b1, 1'b0, 2);

        $display("[TB] empty load");
        busy_cycles = 0;
        pulseStart();
        checkOutput("t2_done_cleared", {31'd0, done}, 32'd0);
        sendFrame('{8'h00, 8'h00, 8'h00}, 1'b0, -1);
        checkFlags("t2", 1'b1, 1'b0, 0);
        checkOutput("t2_busy_cycles", 32'(busy_cycles), 32'd3);

        $display("[TB] length overflow");
        pulseStart();
        sendFrame('{8'h41, 8'h00}, 1'b0, -1);
        checkFlags("t3", 1'b0, 1'b1, 0);
        checkOutput("t3_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] bad checksum");
        pushTwoWords();
        pulseStart();
        checkOutput("t4_err_cleared", {31'd0, err}, 32'd0);
        sendFrame(bad_frame, 1'b0, -1);
        checkFlags("t4", 1'b0, 1'b1, 2);

        $display("[TB] gapped stream with stray start");
        pushTwoWords();
        pulseStart();
        sendFrame(good_frame, 1'b1, 5);
        checkFlags("t5", 1'b1, 1'b0, 2);

        $display("[TB] reset mid-load");
        exp_q.push_back('{addr: 8'h00, data: 32'h0000_0013});
        pulseStart();
        sendFrame(part_frame, 1'b0, -1);
        checkOutput("t6_words_before", {25'd0, words_loaded}, 32'd1);
        checkOutput("t6_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushTwoWords();
        pulseStart();
        sendFrame(good_frame, 1'b0, -1);
        checkFlags("t6_reload", 1'b1, 1'b0, 2);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("writes_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
